dac_adc_tx: RTL and testbench

- One-shot acquisition sequencer. A `start_i` pulse triggers three steps in order:
  - write one 16-bit word to an SPI DAC (mode 0);
  - read one 16-bit frame from an SPI ADC (mode 0);
  - send the 12-bit ADC result as two UART bytes (8N1).
- Sits between the board SPI DAC/ADC pins and the host UART link. `eos_o` marks the end of the sequence.

---
 rtl/dac_adc_tx_if.sv | 42 ++++
 rtl/dac_adc_tx.sv | 170 +++++++++++++++++
 tb/tb_dac_adc_tx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_adc_tx_if.sv
// Pin bundle for the dac_adc_tx acquisition sequencer: SPI DAC, SPI ADC,
// UART transmit line, start request and end-of-sequence strobe.
interface dac_adc_tx_if;
    logic start_i;
    logic miso_adc_i;
    logic mosi_dac_o;
    logic dclk_o;
    logic cs_dac_o;
    logic mosi_adc_o;
    logic sck_o;
    logic cs_adc_o;
    logic tx_o;
    logic eos_o;

    // Sequencer side
    modport master (
        input  start_i,
        input  miso_adc_i,
        output mosi_dac_o,
        output dclk_o,
        output cs_dac_o,
        output mosi_adc_o,
        output sck_o,
        output cs_adc_o,
        output tx_o,
        output eos_o
    );

    // Board / host side
    modport slave (
        output start_i,
        output miso_adc_i,
        input  mosi_dac_o,
        input  dclk_o,
        input  cs_dac_o,
        input  mosi_adc_o,
        input  sck_o,
        input  cs_adc_o,
        input  tx_o,
        input  eos_o
    );
endinterface

// File: rtl/dac_adc_tx.sv
// One-shot acquisition sequencer: on start, write one word to an SPI DAC,
// read one frame from an SPI ADC, then send the 12-bit result over UART
// (8N1) as two bytes and pulse eos_o.
// Optional feature: define DAC_RAMP_EN to make the DAC data field a 12-bit
// counter that starts at DAC_WORD[11:0] and advances after each sequence.
module dac_adc_tx #(
    parameter int          SPI_HALF = 5,
    parameter int          BAUD_DIV = 868,
    parameter logic [15:0] DAC_WORD = 16'h3800,
    parameter logic [15:0] ADC_CMD  = 16'hD000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dac_adc_tx_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, DAC_WR, GAP, ADC_RD, TX_HI, TX_LO, DONE
    } state_t;

    state_t      state, state_nx;
    logic [15:0] cnt;        // clocks within SPI half period / gap / UART bit
    logic [5:0]  half;       // SPI half-period index within a frame, 0..33
    logic        sclk;
    logic        mosi;
    logic [15:0] sreg;       // outgoing SPI frame
    logic [11:0] rreg;       // last 12 bits received from the ADC
    logic [7:0]  lo_byte;
    logic [9:0]  txsh;       // UART frame {stop, data, start}, LSB on the line
    logic [3:0]  bcnt;       // UART bit index, 0..9
    logic [15:0] dac_frame;

    logic half_end, spi_last, baud_end, uart_last;

    assign half_end  = (cnt == 16'(SPI_HALF - 1));
    assign spi_last  = half_end && (half == 6'd33);
    assign baud_end  = (cnt == 16'(BAUD_DIV - 1));
    assign uart_last = baud_end && (bcnt == 4'd9);

`ifdef DAC_RAMP_EN
    logic [11:0] ramp;

    // DAC data ramp, advanced once per completed sequence
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ramp <= DAC_WORD[11:0];
        else if (state == DONE)
            ramp <= ramp + 12'd1;
    end

    assign dac_frame = {DAC_WORD[15:12], ramp};
`else
    assign dac_frame = DAC_WORD;
`endif

    // Sequencer state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start_i) state_nx = DAC_WR;
            DAC_WR:  if (spi_last)    state_nx = GAP;
            GAP:     if (half_end)    state_nx = ADC_RD;
            ADC_RD:  if (spi_last)    state_nx = TX_HI;
            TX_HI:   if (uart_last)   state_nx = TX_LO;
            TX_LO:   if (uart_last)   state_nx = DONE;
            DONE:                     state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // Shared SPI shifter and UART serializer; only one is busy per state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            half    <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            sreg    <= '0;
            rreg    <= '0;
            lo_byte <= '0;
            txsh    <= '1;
            bcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        cnt  <= '0;
                        half <= '0;
                        sclk <= 1'b0;
                        sreg <= dac_frame;
                        mosi <= dac_frame[15];
                    end
                end
                DAC_WR, ADC_RD: begin
                    if (half_end) begin
                        cnt  <= '0;
                        half <= half + 6'd1;
                        if (half == 6'd33) begin
                            sclk <= 1'b0;
                            mosi <= 1'b0;
                            if (state == ADC_RD) begin
                                lo_byte <= rreg[7:0];
                                txsh    <= {1'b1, 4'h0, rreg[11:8], 1'b0};
                                bcnt    <= '0;
                            end
                        end else if (half <= 6'd31) begin
                            if (!half[0]) begin
                                // rising edge: sample the ADC data line
                                sclk <= 1'b1;
                                rreg <= {rreg[10:0], bus.miso_adc_i};
                            end else begin
                                // falling edge: present the next bit
                                sclk <= 1'b0;
                                sreg <= {sreg[14:0], 1'b0};
                                mosi <= sreg[14];
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (half_end) begin
                        cnt  <= '0;
                        half <= '0;
                        sreg <= ADC_CMD;
                        mosi <= ADC_CMD[15];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                TX_HI, TX_LO: begin
                    if (baud_end) begin
                        cnt <= '0;
                        if (bcnt == 4'd9) begin
                            bcnt <= '0;
                            if (state == TX_HI)
                                txsh <= {1'b1, lo_byte, 1'b0};
                            else
                                txsh <= '1;
                        end else begin
                            bcnt <= bcnt + 4'd1;
                            txsh <= {1'b1, txsh[9:1]};
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are gated by the owning state so the idle bus stays quiet
    assign bus.cs_dac_o   = (state != DAC_WR);
    assign bus.dclk_o     = sclk && (state == DAC_WR);
    assign bus.mosi_dac_o = mosi && (state == DAC_WR);
    assign bus.cs_adc_o   = (state != ADC_RD);
    assign bus.sck_o      = sclk && (state == ADC_RD);
    assign bus.mosi_adc_o = mosi && (state == ADC_RD);
    assign bus.tx_o       = txsh[0];
    assign bus.eos_o      = (state == DONE);
endmodule

// File: tb/tb_dac_adc_tx.sv
// Self-checking bench for dac_adc_tx with shortened SPI/UART timing.
// Honours DAC_RAMP_EN in its reference model when compiled with it.
module tb_dac_adc_tx;
    localparam int          SH  = 3;
    localparam int          BD  = 16;
    localparam logic [15:0] DW  = 16'h3FFF;
    localparam logic [15:0] AC  = 16'hD000;
    localparam int          L   = 69 * SH + 20 * BD;
    localparam int          TMO = 4 * L;

    typedef struct {
        logic [15:0] pat;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          bus_viol = 0;
    logic [11:0] ramp_m;
    vec_t        vecs[8];

    dac_adc_tx_if bus();

    dac_adc_tx #(
        .SPI_HALF(SH),
        .BAUD_DIV(BD),
        .DAC_WORD(DW),
        .ADC_CMD (AC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // At most one SPI bus may be selected; an idle bus keeps its clock low
    always @(negedge clk) begin
        if (!bus.cs_dac_o && !bus.cs_adc_o) bus_viol++;
        if (bus.cs_dac_o && bus.dclk_o) bus_viol++;
        if (bus.cs_adc_o && bus.sck_o) bus_viol++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_dac();
`ifdef DAC_RAMP_EN
        return {DW[15:12], ramp_m};
`else
        return DW;
`endif
    endfunction

    function automatic logic [7:0] idle_vec();
        return {bus.cs_dac_o, bus.cs_adc_o, bus.dclk_o, bus.sck_o,
                bus.mosi_dac_o, bus.mosi_adc_o, bus.tx_o, bus.eos_o};
    endfunction

    task automatic spi_cap(input bit adc, input logic [15:0] pat,
                           output logic [15:0] got, output int rises, output bit ok);
        logic s, p;
        int idx;
        got = '0; rises = 0; ok = 0; p = 1'b0; idx = 14;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if ((adc ? bus.cs_adc_o : bus.cs_dac_o) == 1'b0) begin ok = 1; break; end
        end
        if (!ok) return;
        if (adc) bus.miso_adc_i = pat[15];
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            s = adc ? bus.sck_o : bus.dclk_o;
            if (s && !p) begin
                got = {got[14:0], (adc ? bus.mosi_adc_o : bus.mosi_dac_o)};
                rises++;
            end
            if (!s && p && adc && idx >= 0) begin
                bus.miso_adc_i = pat[idx];
                idx--;
            end
            p = s;
            if (adc ? bus.cs_adc_o : bus.cs_dac_o) begin ok = 1; break; end
        end
    endtask

    task automatic uart_rx(output logic [7:0] b, output int unsigned t, output bit ok);
        logic st, sp;
        b = '0; t = 0; ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (!bus.tx_o) begin ok = 1; t = cyc; break; end
        end
        if (!ok) return;
        repeat (BD / 2) @(negedge clk);
        st = bus.tx_o;
        for (int k = 0; k < 8; k++) begin
            repeat (BD) @(negedge clk);
            b[k] = bus.tx_o;
        end
        repeat (BD) @(negedge clk);
        sp = bus.tx_o;
        ok = (st == 1'b0) && (sp == 1'b1);
    endtask

    task automatic run_txn(input logic [15:0] pat, input logic [7:0] hi, input logic [7:0] lo,
                           input bit repulse, input string tag);
        logic [15:0] d_got, a_got, exp_d;
        logic [7:0]  b1, b2;
        int          d_r, a_r;
        bit          d_ok, a_ok, u1, u2, e_ok, e_single;
        int unsigned t0, t1, t2, te, lat;
        e_ok = 0; e_single = 0; te = 0;
        exp_d = exp_dac();
        @(negedge clk) bus.start_i = 1'b1;
        @(negedge clk) bus.start_i = 1'b0;
        t0 = cyc;
        fork
            spi_cap(1'b0, 16'h0000, d_got, d_r, d_ok);
            spi_cap(1'b1, pat, a_got, a_r, a_ok);
            begin
                uart_rx(b1, t1, u1);
                uart_rx(b2, t2, u2);
            end
            begin
                for (int i = 0; i < TMO; i++) begin
                    @(negedge clk);
                    if (bus.eos_o) begin e_ok = 1; te = cyc; break; end
                end
                @(negedge clk);
                e_single = e_ok && !bus.eos_o;
            end
            begin
                if (repulse) begin
                    for (int i = 0; i < TMO; i++) begin
                        @(negedge clk);
                        if (!bus.cs_adc_o) break;
                    end
                    repeat (5) @(negedge clk);
                    bus.start_i = 1'b1;
                    @(negedge clk) bus.start_i = 1'b0;
                end
            end
        join
        lat = te - t0;
        check({tag, "_dac_frame_done"}, 32'(d_ok), 32'd1);
        check({tag, "_dac_word"}, 32'(d_got), 32'(exp_d));
        check({tag, "_dac_edges"}, 32'(d_r), 32'd16);
        check({tag, "_adc_frame_done"}, 32'(a_ok), 32'd1);
        check({tag, "_adc_cmd"}, 32'(a_got), 32'(AC));
        check({tag, "_adc_edges"}, 32'(a_r), 32'd16);
        check({tag, "_uart_framing"}, {30'd0, u1, u2}, 32'd3);
        check({tag, "_byte_hi"}, 32'(b1), 32'(hi));
        check({tag, "_byte_lo"}, 32'(b2), 32'(lo));
        check({tag, "_byte_spacing"}, t2 - t1, 32'(10 * BD));
        check({tag, "_eos_seen"}, 32'(e_ok), 32'd1);
        check({tag, "_eos_one_cycle"}, 32'(e_single), 32'd1);
        tests++;
        if (lat + 1 < 32'(1 + L) || lat > 32'(2 + L)) begin
            fails++;
            $display("FAIL %s_latency: got %0d clocks, want %0d +/-1", tag, lat, 1 + L);
        end
        if (e_ok) ramp_m = ramp_m + 12'd1;
    endtask

    initial begin
        int bad;
        bit ok;
        logic [15:0] r;
        bus.start_i = 1'b0;
        bus.miso_adc_i = 1'b0;
        ramp_m = DW[11:0];

        // Stimulus table: fixed cases first, then random frames with model results
        vecs[0] = '{16'hFFFF, 8'h0F, 8'hFF};
        vecs[1] = '{16'h0A5C, 8'h0A, 8'h5C};
        vecs[2] = '{16'h0000, 8'h00, 8'h00};
        vecs[3] = '{16'hF123, 8'h01, 8'h23};
        for (int i = 4; i < 8; i++) begin
            r = 16'($urandom);
            vecs[i].pat = r;
            vecs[i].hi  = 8'((r % 4096) / 256);
            vecs[i].lo  = 8'(r % 256);
        end

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(idle_vec()), 32'h0000_00C2);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (idle_vec() != 8'hC2) bad++;
        end
        check("idle_no_start", 32'(bad), 32'd0);

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].pat, vecs[i].hi, vecs[i].lo, 1'b0, $sformatf("vec%0d", i));

        // Start re-pulsed during the ADC frame must not launch another sequence
        run_txn(16'h0A5C, 8'h0A, 8'h5C, 1'b1, "repulse");
        bad = 0;
        for (int i = 0; i < 2 * L; i++) begin
            @(negedge clk);
            if (!bus.cs_dac_o || !bus.cs_adc_o || bus.eos_o) bad++;
        end
        check("repulse_ignored", 32'(bad), 32'd0);

        // Reset asserted during the UART phase aborts the sequence
        @(negedge clk) bus.start_i = 1'b1;
        @(negedge clk) bus.start_i = 1'b0;
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (!bus.tx_o) begin ok = 1; break; end
        end
        check("abort_reached_uart", 32'(ok), 32'd1);
        repeat (3 * BD) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", 32'(idle_vec()), 32'h0000_00C2);
        ramp_m = DW[11:0];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 2 * L; i++) begin
            @(negedge clk);
            if (idle_vec() != 8'hC2) bad++;
        end
        check("abort_stays_idle", 32'(bad), 32'd0);

        run_txn(16'h0A5C, 8'h0A, 8'h5C, 1'b0, "recover");
        run_txn(16'hFFFF, 8'h0F, 8'hFF, 1'b0, "recover2");

        check("single_bus_active", 32'(bus_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
